// File: rtl/ascon_byte_loader.sv
// ascon_byte_loader: byte-stream writer that assembles three 128-bit Ascon operands plus the mode and strobes the core.
// Optional: define ASCON_LOADER_CLEAR_EN to let header bit 6 zero all operand registers.
module ascon_byte_loader #(
   parameter int REG_BYTES    = 16,
   parameter int NUM_OPERANDS = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   data_in,
   input  logic         data_valid,
   output logic         data_ready,
   output logic         loader_busy,
   output logic [127:0] reg0_128b,
   output logic [127:0] reg1_128b,
   output logic [127:0] reg2_128b,
   output logic [2:0]   operation_mode,
   output logic         operation_ready
);
   typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;
   state_t state, state_nxt;
   logic [3:0] byte_ctr;
   logic [1:0] reg_idx, nregs;
   logic       start, accept, reg_done, last_byte;
   logic       unused;
   assign unused      = ^{data_in[7:6]};
   assign data_ready  = state != ISSUE;
   assign loader_busy = state != IDLE;
   assign accept      = data_valid && data_ready;
   assign reg_done    = byte_ctr == 4'(REG_BYTES - 1);
   assign last_byte   = state == LOAD && accept && reg_done && reg_idx + 2'd1 == nregs;
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = !accept ? IDLE : data_in[4:3] != 2'd0 ? LOAD : data_in[5] ? ISSUE : IDLE;
         LOAD:  state_nxt = !last_byte ? LOAD : start ? ISSUE : IDLE;
         ISSUE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         byte_ctr        <= '0;
         reg_idx         <= '0;
         nregs           <= '0;
         start           <= 1'b0;
         reg0_128b       <= '0;
         reg1_128b       <= '0;
         reg2_128b       <= '0;
         operation_mode  <= '0;
         operation_ready <= 1'b0;
      end else begin
         state           <= state_nxt;
         operation_ready <= state_nxt == ISSUE;
         if (state == IDLE && accept) begin
            operation_mode <= data_in[2:0];
            nregs          <= data_in[4:3];
            start          <= data_in[5];
            byte_ctr       <= '0;
            reg_idx        <= '0;
`ifdef ASCON_LOADER_CLEAR_EN
            if (data_in[6]) begin
               reg0_128b <= '0;
               reg1_128b <= '0;
               reg2_128b <= '0;
            end
`endif
         end else if (state == LOAD && accept) begin
            // reg_idx only ever takes 0..2 here because LOAD exits once it reaches nregs
            if (reg_idx == 2'd0) reg0_128b <= {reg0_128b[119:0], data_in};
            else if (reg_idx == 2'd1) reg1_128b <= {reg1_128b[119:0], data_in};
            else reg2_128b <= {reg2_128b[119:0], data_in};
            byte_ctr <= reg_done ? 4'd0 : byte_ctr + 4'd1;
            if (reg_done) reg_idx <= reg_idx + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_ascon_byte_loader.sv
// tb_ascon_byte_loader: directed table and sequence checks for ascon_byte_loader.
module tb_ascon_byte_loader;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   data_in = '0;
   logic         data_valid = 1'b0;
   logic         data_ready, loader_busy, operation_ready;
   logic [127:0] reg0_128b, reg1_128b, reg2_128b;
   logic [2:0]   operation_mode;
   int           nvec = 0, nerr = 0, strobes = 0, s0;
   logic [127:0] e0, e1;

   ascon_byte_loader dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .loader_busy(loader_busy),
      .reg0_128b(reg0_128b), .reg1_128b(reg1_128b), .reg2_128b(reg2_128b),
      .operation_mode(operation_mode), .operation_ready(operation_ready)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (operation_ready === 1'b1) strobes++;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       rdy, busy, op;
      logic [2:0] mode;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      data_valid = v;
      data_in    = d;
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3};
      tbl[2] = '{1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 3'd3};
      tbl[3] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 3'd3};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3};
      tbl[5] = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 3'd3};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2};

      #12;
      chk("rst_busy", 128'(loader_busy), 128'd0);
      chk("rst_op", 128'(operation_ready), 128'd0);
      chk("rst_mode", 128'(operation_mode), 128'd0);
      chk("rst_regs", reg0_128b | reg1_128b | reg2_128b, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_ready", 128'(data_ready), 128'd1);

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_ready", i), 128'(data_ready), 128'(tbl[i].rdy));
         chk($sformatf("tbl%0d_busy", i), 128'(loader_busy), 128'(tbl[i].busy));
         chk($sformatf("tbl%0d_op", i), 128'(operation_ready), 128'(tbl[i].op));
         chk($sformatf("tbl%0d_mode", i), 128'(operation_mode), 128'(tbl[i].mode));
      end
      chk("drop_regs", reg0_128b | reg1_128b | reg2_128b, 128'd0);
      chk("tbl_strobes", 128'(strobes), 128'd1);

      // finish the nregs=1, start=0 load begun by header 0x0A
      e0 = '0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'hC0 + i));
         e0 = {e0[119:0], 8'(8'hC0 + i)};
      end
      step(1'b0, 8'h00);
      chk("nostart_busy", 128'(loader_busy), 128'd0);
      chk("nostart_reg0", reg0_128b, e0);
      chk("nostart_reg1", reg1_128b, 128'd0);
      chk("nostart_strobes", 128'(strobes), 128'd1);

      // AEAD load: key then nonce
      s0 = strobes;
      step(1'b1, 8'h31);
      e0 = '0;
      e1 = '0;
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 8'(i));
         if (i < 16) e0 = {e0[119:0], 8'(i)};
         else e1 = {e1[119:0], 8'(i)};
      end
      step(1'b0, 8'h00);
      chk("aead_op", 128'(operation_ready), 128'd1);
      chk("aead_ready", 128'(data_ready), 128'd0);
      chk("aead_reg0", reg0_128b, e0);
      chk("aead_reg1", reg1_128b, e1);
      chk("aead_reg2", reg2_128b, 128'd0);
      chk("aead_mode", 128'(operation_mode), 128'd1);
      step(1'b0, 8'h00);
      chk("aead_op_off", 128'(operation_ready), 128'd0);
      chk("aead_strobes", 128'(strobes - s0), 128'd1);

      // stalled three-register load, data_valid toggling
      s0 = strobes;
      step(1'b1, 8'h39);
      for (int i = 0; i < 48; i++) begin
         step(1'b1, 8'hFF);
         step(1'b0, 8'h00);
         if (i == 20) chk("stall_busy", 128'(loader_busy), 128'd1);
      end
      chk("stall_op", 128'(operation_ready), 128'd1);
      chk("stall_regs", reg0_128b & reg1_128b & reg2_128b, {128{1'b1}});
      step(1'b0, 8'h00);
      chk("stall_strobes", 128'(strobes - s0), 128'd1);

      // reset in the middle of reg0
      s0 = strobes;
      step(1'b1, 8'h09);
      for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
      @(negedge clk);
      data_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_regs", reg0_128b | reg1_128b | reg2_128b, 128'd0);
      chk("mid_rst_mode", 128'(operation_mode), 128'd0);
      chk("mid_rst_busy", 128'(loader_busy), 128'd0);
      rst_n = 1'b1;
      step(1'b1, 8'h0C);
      e0 = '0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h80 + i));
         if (i == 0) chk("after_rst_busy", 128'(loader_busy), 128'd1);
         e0 = {e0[119:0], 8'(8'h80 + i)};
      end
      step(1'b0, 8'h00);
      chk("after_rst_reg0", reg0_128b, e0);
      chk("after_rst_mode", 128'(operation_mode), 128'd4);
      chk("after_rst_strobes", 128'(strobes - s0), 128'd0);

      // preload all registers to ones, then a clear header
      step(1'b1, 8'h18);
      for (int i = 0; i < 48; i++) step(1'b1, 8'hFF);
      step(1'b0, 8'h00);
      chk("preload_reg2", reg2_128b, {128{1'b1}});
      step(1'b1, 8'h49);
      step(1'b0, 8'h00);
      chk("clr_mode", 128'(operation_mode), 128'd1);
`ifdef ASCON_LOADER_CLEAR_EN
      chk("clr_reg1", reg1_128b, 128'd0);
      chk("clr_reg2", reg2_128b, 128'd0);
`else
      chk("clr_reg1", reg1_128b, {128{1'b1}});
      chk("clr_reg2", reg2_128b, {128{1'b1}});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
